// File: rtl/inst_loader_if.sv
// Byte-stream and instruction-memory write bundle for the boot loader.
// The slave side is the loader; the master side feeds bytes and watches the memory port.
interface inst_loader_if #(
  parameter int ADDR_W = 6
);
  logic              load_req;
  logic [7:0]        rx_data;
  logic              rx_valid;
  logic              rx_ready;
  logic              wea;
  logic [ADDR_W-1:0] addra;
  logic [31:0]       dina;
  logic              cpu_hold;
  logic              done;
  logic              err;
  logic [1:0]        err_code;

  modport master (
    output load_req, rx_data, rx_valid,
    input  rx_ready, wea, addra, dina, cpu_hold, done, err, err_code
  );

  modport slave (
    input  load_req, rx_data, rx_valid,
    output rx_ready, wea, addra, dina, cpu_hold, done, err, err_code
  );
endinterface

// File: rtl/inst_loader.sv
// Boot-time instruction memory writer: count byte, big-endian words, XOR checksum.
// Keeps the CPU held in reset until a complete, checksum-verified image is in memory.
module inst_loader #(
  parameter int ADDR_W    = 6,
  parameter int TIMEOUT   = 1000000,
  parameter bit BOOT_HOLD = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  inst_loader_if.slave bus
);
  localparam int CW  = ADDR_W + 1;
  localparam int CAP = 1 << ADDR_W;
  localparam int TW  = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_COUNT = 3'd1,
    S_DATA  = 3'd2,
    S_CHECK = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  localparam state_t RST_STATE = BOOT_HOLD ? S_COUNT : S_IDLE;

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [CW-1:0]     widx_q, widx_d;
  logic [1:0]        bidx_q, bidx_d;
  logic [23:0]       shift_q, shift_d;
  logic [7:0]        csum_q, csum_d;
  logic [TW-1:0]     tmr_q, tmr_d;
  logic              rx_ready_q, rx_ready_d;
  logic              wea_q, wea_d;
  logic [ADDR_W-1:0] addra_q, addra_d;
  logic [31:0]       dina_q, dina_d;
  logic              cpu_hold_q, cpu_hold_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic [1:0]        err_code_q, err_code_d;

  logic          acc_s;
  logic          timed_out_s;
  logic [CW-1:0] widx_nxt_s;

  assign acc_s       = bus.rx_valid & rx_ready_q;
  assign widx_nxt_s  = widx_q + CW'(1);
  // The idle counter only runs mid-load; hitting TIMEOUT-1 with no byte means this edge reaches TIMEOUT.
  assign timed_out_s = ((state_q == S_DATA) || (state_q == S_CHECK)) && !acc_s
                       && (tmr_q == TW'(TIMEOUT - 1));

  // Next-state and registered-output computation for the load sequencer.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    widx_d     = widx_q;
    bidx_d     = bidx_q;
    shift_d    = shift_q;
    csum_d     = csum_q;
    tmr_d      = '0;
    wea_d      = 1'b0;
    addra_d    = addra_q;
    dina_d     = dina_q;
    cpu_hold_d = cpu_hold_q;
    done_d     = 1'b0;
    err_d      = err_q;
    err_code_d = err_code_q;

    case (state_q)
      S_IDLE: begin
        if (bus.load_req) begin
          err_d      = 1'b0;
          err_code_d = 2'b00;
          widx_d     = '0;
          bidx_d     = 2'd0;
          csum_d     = 8'h00;
          cpu_hold_d = 1'b1;
          state_d    = S_COUNT;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_COUNT: begin
        if (!acc_s) begin
          state_d = S_COUNT;
        end else if (bus.rx_data == 8'h00) begin
          cnt_d   = CW'(CAP);
          state_d = S_DATA;
        end else if (int'(bus.rx_data) <= CAP) begin
          cnt_d   = CW'(bus.rx_data);
          state_d = S_DATA;
        end else begin
          err_d      = 1'b1;
          err_code_d = 2'b11;
          state_d    = S_IDLE;
        end
      end
      S_DATA: begin
        if (acc_s) begin
          csum_d  = csum_q ^ bus.rx_data;
          shift_d = {shift_q[15:0], bus.rx_data};
          bidx_d  = bidx_q + 2'd1;
          if (bidx_q == 2'd3) begin
            wea_d   = 1'b1;
            addra_d = widx_q[ADDR_W-1:0];
            dina_d  = {shift_q, bus.rx_data};
            widx_d  = widx_nxt_s;
            state_d = (widx_nxt_s == cnt_q) ? S_CHECK : S_DATA;
          end else begin
            state_d = S_DATA;
          end
        end else if (timed_out_s) begin
          err_d      = 1'b1;
          err_code_d = 2'b10;
          state_d    = S_IDLE;
        end else begin
          tmr_d = tmr_q + TW'(1);
        end
      end
      S_CHECK: begin
        if (acc_s) begin
          if (bus.rx_data == csum_q) begin
            done_d     = 1'b1;
            cpu_hold_d = 1'b0;
            state_d    = S_DONE;
          end else begin
            err_d      = 1'b1;
            err_code_d = 2'b01;
            state_d    = S_IDLE;
          end
        end else if (timed_out_s) begin
          err_d      = 1'b1;
          err_code_d = 2'b10;
          state_d    = S_IDLE;
        end else begin
          tmr_d = tmr_q + TW'(1);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    rx_ready_d = (state_d == S_COUNT) || (state_d == S_DATA) || (state_d == S_CHECK);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= RST_STATE;
      cnt_q      <= '0;
      widx_q     <= '0;
      bidx_q     <= 2'd0;
      shift_q    <= 24'h000000;
      csum_q     <= 8'h00;
      tmr_q      <= '0;
      rx_ready_q <= BOOT_HOLD;
      wea_q      <= 1'b0;
      addra_q    <= '0;
      dina_q     <= 32'h00000000;
      cpu_hold_q <= BOOT_HOLD;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      err_code_q <= 2'b00;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      widx_q     <= widx_d;
      bidx_q     <= bidx_d;
      shift_q    <= shift_d;
      csum_q     <= csum_d;
      tmr_q      <= tmr_d;
      rx_ready_q <= rx_ready_d;
      wea_q      <= wea_d;
      addra_q    <= addra_d;
      dina_q     <= dina_d;
      cpu_hold_q <= cpu_hold_d;
      done_q     <= done_d;
      err_q      <= err_d;
      err_code_q <= err_code_d;
    end
  end

  assign bus.rx_ready = rx_ready_q;
  assign bus.wea      = wea_q;
  assign bus.addra    = addra_q;
  assign bus.dina     = dina_q;
  assign bus.cpu_hold = cpu_hold_q;
  assign bus.done     = done_q;
  assign bus.err      = err_q;
  assign bus.err_code = err_code_q;
endmodule
